// File: rtl/dm_bus_arbiter.sv
// Purpose : arbitrates one shared memory bus between the CPU MEM stage and a word-only DMA engine.
// Latency : grant on the edge after an IDLE request; completes in the first busy cycle with bus_ready (min 1 cycle).
// Backpress: cpu_stall holds the CPU until its access completes; DMA holds dma_req until dma_ack.
//
// Ports:
//   clk, rst                     clock (rising edge) and asynchronous active-high reset
//   cpu_req/we/size/addr/wdata   CPU access request (size 00 word, 01 half, 10 byte)
//   cpu_rdata/stall/adel/ades    CPU read data, stall, misaligned load/store flags
//   dma_req/we/addr/wdata        DMA word request
//   dma_rdata/ack                DMA read data and one-cycle completion pulse
//   bus_req/we/addr/wdata/byteen registered bus command, constant while busy
//   bus_rdata/ready              bus response
//   bus_err                      one-cycle pulse when an access is aborted by timeout
module dm_bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_adel,
    output logic        cpu_ades,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DMA = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  busy_cnt;
    logic [7:0]  starve_cnt;
    logic        cpu_misaligned;
    logic        cpu_ok;
    logic        dma_force;
    logic        grant_cpu;
    logic        grant_dma;
    logic        busy;
    logic        timeout_hit;
    logic        done;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_wdata_rep;

    // DMA is word-only, so the low address bits carry no information.
    logic unused_dma_lsb;
    assign unused_dma_lsb = ^dma_addr[1:0];

    // Alignment and write-lane formatting for the CPU request.
    always_comb begin
        cpu_misaligned = 1'b0;
        cpu_byteen     = 4'b1111;
        cpu_wdata_rep  = cpu_wdata;
        case (cpu_size)
            2'b01: begin
                cpu_misaligned = cpu_addr[0];
                cpu_byteen     = cpu_addr[1] ? 4'b1100 : 4'b0011;
                cpu_wdata_rep  = {2{cpu_wdata[15:0]}};
            end
            2'b10: begin
                cpu_byteen     = 4'b0001 << cpu_addr[1:0];
                cpu_wdata_rep  = {4{cpu_wdata[7:0]}};
            end
            default: cpu_misaligned = |cpu_addr[1:0];
        endcase
    end

    assign cpu_ok      = cpu_req && !cpu_misaligned;
    assign dma_force   = dma_req && (starve_cnt == 8'(STARVE_MAX));
    assign grant_cpu   = (state == IDLE) && cpu_ok && !dma_force;
    assign grant_dma   = (state == IDLE) && dma_req && !grant_cpu;
    assign busy        = (state != IDLE);
    assign timeout_hit = busy && !bus_ready && (busy_cnt == 8'(TIMEOUT - 1));
    assign done        = busy && (bus_ready || timeout_hit);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_cpu)      state_nxt = BUSY_CPU;
                else if (grant_dma) state_nxt = BUSY_DMA;
            end
            BUSY_CPU, BUSY_DMA: if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Requester-facing outputs. Everything is forced low while reset is held,
    // including the purely input-driven IDLE decodes.
    always_comb begin
        cpu_stall = 1'b0;
        cpu_adel  = 1'b0;
        cpu_ades  = 1'b0;
        cpu_rdata = 32'h0;
        dma_rdata = 32'h0;
        dma_ack   = 1'b0;
        bus_err   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    cpu_stall = cpu_ok;
                    cpu_adel  = cpu_req && cpu_misaligned && !cpu_we;
                    cpu_ades  = cpu_req && cpu_misaligned && cpu_we;
                end
                BUSY_CPU: begin
                    cpu_stall = cpu_ok && !done;
                    cpu_rdata = bus_ready ? bus_rdata : 32'h0;
                    bus_err   = timeout_hit;
                end
                BUSY_DMA: begin
                    cpu_stall = cpu_ok;
                    dma_ack   = done;
                    dma_rdata = bus_ready ? bus_rdata : 32'h0;
                    bus_err   = timeout_hit;
                end
                default: ;
            endcase
        end
    end

    // Bus command registers: loaded on the grant edge, held while busy,
    // cleared on completion so the bus idles with a quiet command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_byteen <= 4'b0000;
        end else if (grant_cpu) begin
            bus_req    <= 1'b1;
            bus_we     <= cpu_we;
            bus_addr   <= {cpu_addr[31:2], 2'b00};
            bus_wdata  <= cpu_we ? cpu_wdata_rep : 32'h0;
            bus_byteen <= cpu_we ? cpu_byteen : 4'b0000;
        end else if (grant_dma) begin
            bus_req    <= 1'b1;
            bus_we     <= dma_we;
            bus_addr   <= {dma_addr[31:2], 2'b00};
            bus_wdata  <= dma_we ? dma_wdata : 32'h0;
            bus_byteen <= dma_we ? 4'b1111 : 4'b0000;
        end else if (done) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_byteen <= 4'b0000;
        end
    end

    // Busy-cycle counter for the timeout abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  busy_cnt <= 8'd0;
        else if (grant_cpu || grant_dma || done) busy_cnt <= 8'd0;
        else if (busy)            busy_cnt <= busy_cnt + 8'd1;
    end

    // Starvation counter. A DMA grant that only happened because the CPU
    // request was misaligned does not reset fairness history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 8'd0;
        end else if (grant_cpu && dma_req) begin
            if (starve_cnt != 8'(STARVE_MAX)) starve_cnt <= starve_cnt + 8'd1;
        end else if (grant_dma && !(cpu_req && cpu_misaligned)) begin
            starve_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
module tb_dm_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_adel;
    logic        cpu_ades;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;

    int n_cmp;
    int n_fail;

    dm_bus_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_adel(cpu_adel), .cpu_ades(cpu_ades),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_byteen(bus_byteen), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_size = 2'b00; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        bus_rdata = 0; bus_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        step();
        // Aligned and misaligned requests under reset must not leak to outputs.
        cpu_req = 1; cpu_size = 2'b00; cpu_addr = 32'h100; bus_ready = 1; bus_rdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req: got %0h want 0", bus_req); end
        n_cmp++; if ({bus_we, bus_byteen, bus_addr, bus_wdata} !== 69'h0) begin n_fail++; $display("FAIL rst_bus_cmd: got we=%0h be=%0h addr=%0h wd=%0h want all 0", bus_we, bus_byteen, bus_addr, bus_wdata); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0h want 0", cpu_stall); end
        n_cmp++; if ({cpu_rdata, dma_rdata, dma_ack, bus_err} !== 66'h0) begin n_fail++; $display("FAIL rst_resp: got crd=%0h drd=%0h ack=%0h err=%0h want 0", cpu_rdata, dma_rdata, dma_ack, bus_err); end
        cpu_addr = 32'h101;
        #1;
        n_cmp++; if ({cpu_adel, cpu_ades} !== 2'b00) begin n_fail++; $display("FAIL rst_adel: got %0b want 00", {cpu_adel, cpu_ades}); end
        clear_inputs();
        step();
        rst = 0;
        step();
    endtask

    task automatic test_cpu_sb();
        cpu_req = 1; cpu_we = 1; cpu_size = 2'b10; cpu_addr = 32'h1003; cpu_wdata = 32'hAB;
        #1;
        n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall_idle: got %0h want 1", cpu_stall); end
        step();
        n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin n_fail++; $display("FAIL sb_req_we: got req=%0h we=%0h want 1 1", bus_req, bus_we); end
        n_cmp++; if (bus_byteen !== 4'b1000) begin n_fail++; $display("FAIL sb_byteen: got %b want 1000", bus_byteen); end
        n_cmp++; if (bus_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h want ababab ab", bus_wdata); end
        n_cmp++; if (bus_addr !== 32'h1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", bus_addr); end
        n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall_busy: got %0h want 1", cpu_stall); end
        step();
        bus_ready = 1;
        #1;
        n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL sb_stall_done: got %0h want 0", cpu_stall); end
        n_cmp++; if (bus_byteen !== 4'b1000 || bus_req !== 1'b1) begin n_fail++; $display("FAIL sb_hold: got be=%b req=%0h want 1000 1", bus_byteen, bus_req); end
        step();
        clear_inputs();
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL sb_idle: got %0h want 0", bus_req); end
        step();
    endtask

    task automatic test_misaligned();
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b00; cpu_addr = 32'h2002;
        #1;
        n_cmp++; if ({cpu_adel, cpu_ades, cpu_stall} !== 3'b100) begin n_fail++; $display("FAIL lw_adel: got adel/ades/stall=%b want 100", {cpu_adel, cpu_ades, cpu_stall}); end
        step();
        n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL lw_no_bus: got %0h want 0", bus_req); end
        cpu_we = 1; cpu_size = 2'b01; cpu_addr = 32'h11;
        #1;
        n_cmp++; if ({cpu_adel, cpu_ades, cpu_stall} !== 3'b010) begin n_fail++; $display("FAIL sh_ades: got adel/ades/stall=%b want 010", {cpu_adel, cpu_ades, cpu_stall}); end
        step();
        n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL sh_no_bus: got %0h want 0", bus_req); end
        // Misaligned CPU plus DMA: flag and grant DMA in the same cycle.
        cpu_we = 0; cpu_size = 2'b00; cpu_addr = 32'h2002;
        dma_req = 1; dma_we = 0; dma_addr = 32'h84;
        #1;
        n_cmp++; if (cpu_adel !== 1'b1) begin n_fail++; $display("FAIL mix_adel: got %0h want 1", cpu_adel); end
        step();
        n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h84) begin n_fail++; $display("FAIL mix_dma_grant: got req=%0h addr=%h want 1 00000084", bus_req, bus_addr); end
        bus_ready = 1; bus_rdata = 32'hCAFE_F00D;
        #1;
        n_cmp++; if (dma_ack !== 1'b1 || dma_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mix_dma_done: got ack=%0h rd=%h want 1 cafef00d", dma_ack, dma_rdata); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_dma_write();
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'hDEAD_BEEF;
        step();
        n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin n_fail++; $display("FAIL dmaw_req_we: got req=%0h we=%0h want 1 1", bus_req, bus_we); end
        n_cmp++; if (bus_byteen !== 4'b1111) begin n_fail++; $display("FAIL dmaw_byteen: got %b want 1111", bus_byteen); end
        n_cmp++; if (bus_wdata !== 32'hDEAD_BEEF || bus_addr !== 32'h40) begin n_fail++; $display("FAIL dmaw_data: got wd=%h addr=%h want deadbeef 00000040", bus_wdata, bus_addr); end
        n_cmp++; if (dma_ack !== 1'b0) begin n_fail++; $display("FAIL dmaw_early_ack: got %0h want 0", dma_ack); end
        step();
        bus_ready = 1;
        #1;
        n_cmp++; if (dma_ack !== 1'b1) begin n_fail++; $display("FAIL dmaw_ack: got %0h want 1", dma_ack); end
        step();
        clear_inputs();
        #1;
        n_cmp++; if (dma_ack !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL dmaw_after: got ack=%0h req=%0h want 0 0", dma_ack, bus_req); end
        // DMA read: no write enables, data returned only to the DMA side.
        dma_req = 1; dma_we = 0; dma_addr = 32'h44;
        step();
        n_cmp++; if (bus_we !== 1'b0 || bus_byteen !== 4'b0000) begin n_fail++; $display("FAIL dmar_cmd: got we=%0h be=%b want 0 0000", bus_we, bus_byteen); end
        bus_ready = 1; bus_rdata = 32'h1234_5678;
        #1;
        n_cmp++; if (dma_rdata !== 32'h1234_5678 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL dmar_rdata: got drd=%h crd=%h want 12345678 0", dma_rdata, cpu_rdata); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr;
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b00; cpu_addr = 32'h100;
        dma_req = 1; dma_we = 0; dma_addr = 32'h200;
        bus_ready = 1; bus_rdata = 32'h1357_2468;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_addr = (i % 5 == 4) ? 32'h200 : 32'h100;
            n_cmp++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL rr_grant%0d: got addr=%h want %h", i, bus_addr, exp_addr); end
            if (i % 5 == 4) begin
                n_cmp++; if (dma_ack !== 1'b1 || dma_rdata !== 32'h1357_2468 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rr_dma%0d: got ack=%0h rd=%h stall=%0h want 1 13572468 1", i, dma_ack, dma_rdata, cpu_stall); end
            end else begin
                n_cmp++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h1357_2468 || dma_ack !== 1'b0) begin n_fail++; $display("FAIL rr_cpu%0d: got stall=%0h rd=%h ack=%0h want 0 13572468 0", i, cpu_stall, cpu_rdata, dma_ack); end
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b00; cpu_addr = 32'h300;
        bus_rdata = 32'hFFFF_FFFF;
        step();
        for (int k = 1; k <= 64; k++) begin
            if (k < 64) begin
                n_cmp++; if (bus_err !== 1'b0 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d: got err=%0h stall=%0h want 0 1", k, bus_err, cpu_stall); end
                step();
            end else begin
                n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %0h want 1", bus_err); end
                n_cmp++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL to_complete: got stall=%0h rd=%h want 0 0", cpu_stall, cpu_rdata); end
            end
        end
        step();
        clear_inputs();
        #1;
        n_cmp++; if (bus_req !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL to_idle: got req=%0h err=%0h want 0 0", bus_req, bus_err); end
        step();
    endtask

    task automatic test_reset_mid_dma();
        dma_req = 1; dma_we = 0; dma_addr = 32'h80;
        step();
        n_cmp++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %0h want 1", bus_req); end
        #2;
        rst = 1;
        #1;
        n_cmp++; if (bus_req !== 1'b0 || dma_ack !== 1'b0) begin n_fail++; $display("FAIL mid_rst_async: got req=%0h ack=%0h want 0 0", bus_req, dma_ack); end
        dma_req = 0; bus_ready = 1;
        step();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (dma_ack !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL mid_after%0d: got ack=%0h req=%0h want 0 0", i, dma_ack, bus_req); end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_cpu_sb();
        test_misaligned();
        test_dma_write();
        test_starvation();
        test_timeout();
        test_reset_mid_dma();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_bus_arbiter.md
DM_BUS_ARBITER -- requirements
Module: dm_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive CPU wins over a pending DMA before DMA is forced.
REQ-002 SHALL have parameter TIMEOUT, default 64 (range 2..255), meaning busy cycles without bus_ready before abort.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_size in 2 (00 word, 01 half, 10 byte), cpu_addr in 32, cpu_wdata in 32: the MEM-stage access.
REQ-006 SHALL have ports cpu_rdata out 32 (raw bus word), cpu_stall out 1, cpu_adel out 1 (misaligned load), cpu_ades out 1 (misaligned store).
REQ-007 SHALL have ports dma_req in 1, dma_we in 1, dma_addr in 32, dma_wdata in 32, dma_rdata out 32, dma_ack out 1: word-only DMA.
REQ-008 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_wdata out 32, bus_byteen out 4, bus_rdata in 32, bus_ready in 1, bus_err out 1.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_CPU, BUSY_DMA; all bus_* outputs registered, loaded on the grant edge and held constant while BUSY.
REQ-010 SHALL, in IDLE, grant CPU when cpu_req is aligned, unless dma_req=1 and starve_cnt==STARVE_MAX, in which case DMA is granted.
REQ-011 SHALL grant DMA in IDLE when dma_req=1 and no aligned cpu_req is present.
REQ-012 SHALL increment starve_cnt (saturating at STARVE_MAX) when CPU is granted while dma_req=1, and clear it when DMA is granted.
REQ-013 SHALL treat word with addr[1:0]!=0 or half with addr[0]!=0 as misaligned; in IDLE, combinationally assert cpu_adel (cpu_we=0) or cpu_ades (cpu_we=1), issue no bus access, keep cpu_stall=0.
REQ-014 SHALL drive bus_addr={addr[31:2],2'b00}.
REQ-015 SHALL for CPU writes set byteen word=1111, half=(addr[1]?1100:0011), byte=0001<<addr[1:0]; wdata replicated: half {2{wdata[15:0]}}, byte {4{wdata[7:0]}}.
REQ-016 SHALL for all reads set bus_we=0, bus_byteen=0000; for DMA writes byteen=1111, wdata unmodified.
REQ-017 SHALL assert bus_req=1 throughout BUSY_CPU/BUSY_DMA and 0 in IDLE.
REQ-018 SHALL complete a BUSY access in the cycle bus_ready=1; FSM returns to IDLE on that edge; minimum latency grant-edge to completion = 1 cycle.
REQ-019 SHALL drive cpu_stall = cpu_req AND aligned AND NOT (state==BUSY_CPU AND completing); stall holds while DMA is busy.
REQ-020 SHALL drive cpu_rdata = bus_rdata during the CPU completion cycle, 0 otherwise; dma_rdata likewise for DMA.
REQ-021 SHALL pulse dma_ack for exactly the DMA completion cycle; dma_req must stay high until ack.
REQ-022 SHALL count busy cycles in an 8-bit counter cleared on each grant; at count==TIMEOUT-1 without bus_ready: abort, pulse bus_err one cycle, complete requester (stall low / dma_ack high) with rdata=0, return IDLE.
REQ-023 SHALL ignore bus_ready in IDLE.
REQ-024 SHALL, with misaligned cpu_req and dma_req both in IDLE, flag the exception and grant DMA the same cycle; starve_cnt unchanged.
REQ-025 SHALL sample a new arbitration decision only in IDLE; no back-to-back grant without one IDLE cycle.

Reset
REQ-026 SHALL on rst=1 immediately force IDLE, bus_req=0, bus_we=0, bus_byteen=0, bus_addr=0, bus_wdata=0, starve_cnt=0, timeout counter=0.
REQ-027 SHALL with rst=1 hold cpu_stall, cpu_adel, cpu_ades, dma_ack, bus_err at 0 and cpu_rdata, dma_rdata at 0.
REQ-028 SHALL abandon an in-flight access on mid-operation reset with no ack/completion issued afterwards.

Verification
REQ-029 SHALL cover: CPU sb addr=0x1003 wdata=0xAB, ready after 2 cycles -> byteen=1000, wdata=0xABABABAB, bus_addr=0x1000, stall high 2 cycles then low.
REQ-030 SHALL cover: CPU lw addr=0x2002 -> cpu_adel=1 same cycle, bus_req stays 0, stall 0; sh addr=0x11 -> cpu_ades=1.
REQ-031 SHALL cover: cpu_req and dma_req held continuously, ready=1 every busy cycle -> 4 CPU grants then 1 DMA grant, repeating.
REQ-032 SHALL cover: CPU lw with bus_ready never asserted, TIMEOUT=64 -> bus_err pulse on 64th busy cycle, cpu_rdata=0, stall drops, FSM IDLE.
REQ-033 SHALL cover: rst asserted mid BUSY_DMA -> bus_req low same cycle without clock edge, no dma_ack after release.
REQ-034 SHALL cover: DMA write 0xDEADBEEF to 0x40 with CPU idle -> byteen=1111, bus_we=1, dma_ack single-cycle pulse on ready.
